// File: rtl/csa_frame_accumulator.sv
// Frame accumulator wrapped around an external combinational carry-select adder.
// Feeds the adder with the running low word and the incoming sample, captures
// sum/cout on every accepted sample, extends the total with a saturating carry
// counter and hands one frame total downstream per FRAME_LEN samples or i_last.
module csa_frame_accumulator #(
  parameter int WIDTH     = 12,
  parameter int FRAME_LEN = 16,
  parameter int CARRY_W   = 4,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_last,
  output logic [WIDTH-1:0]           o_add_term1,
  output logic [WIDTH-1:0]           o_add_term2,
  input  logic [WIDTH-1:0]           i_sum,
  input  logic                       i_cout,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH+CARRY_W-1:0]   o_result,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CARRY_W-1:0]   acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [CNT_W-1:0]     cnt_inc;

  assign accept  = i_valid & (state_q == ACCUM);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state logic: accumulate on accept, close the frame, clear on handoff
  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_lo_d = i_sum;
          // Carry counter saturates instead of wrapping; the flag stays set
          // for the rest of the frame.
          if ((acc_hi_q == '1) && i_cout) begin
            ovf_d = 1'b1;
          end else begin
            acc_hi_d = acc_hi_q + CARRY_W'(i_cout);
          end
          cnt_d = cnt_inc;
          if ((cnt_inc == FRAME_LEN_C) || i_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_d  = ACCUM;
          acc_lo_d = '0;
          acc_hi_d = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and accumulator registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ACCUM;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_ready     = (state_q == ACCUM);
  assign o_valid     = (state_q == HOLD);
  assign o_add_term1 = acc_lo_q;
  assign o_add_term2 = accept ? i_data : '0;
  assign o_result    = {acc_hi_q, acc_lo_q};
  assign o_count     = cnt_q;
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_csa_frame_accumulator.sv
// Scoreboard bench for csa_frame_accumulator: instance A uses FRAME_LEN=16,
// instance B uses FRAME_LEN=20 for the saturation case. Each has its own
// behavioural adder and its own expected-frame queue.
module tb_csa_frame_accumulator;

  localparam int W  = 12;
  localparam int CW = 4;
  localparam int NA = 5;   // $clog2(17)
  localparam int NB = 5;   // $clog2(21)

  typedef struct {
    logic [W+CW-1:0] res;
    logic [4:0]      cnt;
    logic            ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic valid, sel, last, ready;
  logic [W-1:0] data;

  logic valid_a, valid_b;
  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;

  logic          rdy_a, vld_a, ovf_a, cout_a;
  logic [W-1:0]  t1_a, t2_a, sum_a;
  logic [W+CW-1:0] res_a;
  logic [NA-1:0] cnt_a;
  logic          rdy_b, vld_b, ovf_b, cout_b;
  logic [W-1:0]  t1_b, t2_b, sum_b;
  logic [W+CW-1:0] res_b;
  logic [NB-1:0] cnt_b;

  assign {cout_a, sum_a} = {1'b0, t1_a} + {1'b0, t2_a};
  assign {cout_b, sum_b} = {1'b0, t1_b} + {1'b0, t2_b};

  always #5 clk = ~clk;

  csa_frame_accumulator #(.WIDTH(W), .FRAME_LEN(16), .CARRY_W(CW)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_ready(rdy_a),
    .i_data(data), .i_last(last), .o_add_term1(t1_a), .o_add_term2(t2_a),
    .i_sum(sum_a), .i_cout(cout_a), .o_valid(vld_a), .i_ready(ready),
    .o_result(res_a), .o_count(cnt_a), .o_ovf(ovf_a)
  );

  csa_frame_accumulator #(.WIDTH(W), .FRAME_LEN(20), .CARRY_W(CW)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_ready(rdy_b),
    .i_data(data), .i_last(last), .o_add_term1(t1_b), .o_add_term2(t2_b),
    .i_sum(sum_b), .i_cout(cout_b), .o_valid(vld_b), .i_ready(ready),
    .o_result(res_b), .o_count(cnt_b), .o_ovf(ovf_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever a result handshake takes place
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (vld_a && ready) begin
        if (q_a.size() == 0) chk("a_unexpected_frame", 1, 0);
        else begin
          e = q_a.pop_front();
          chk("a_result", res_a, e.res);
          chk("a_count", cnt_a, e.cnt);
          chk("a_ovf", ovf_a, e.ovf);
        end
      end
      if (vld_b && ready) begin
        if (q_b.size() == 0) chk("b_unexpected_frame", 1, 0);
        else begin
          e = q_b.pop_front();
          chk("b_result", res_b, e.res);
          chk("b_count", cnt_b, e.cnt);
          chk("b_ovf", ovf_b, e.ovf);
        end
      end
    end
  end

  // Present one sample to instance s and wait until it is accepted; called
  // at posedge+1, returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [W-1:0] d, input logic l,
                      output int unsigned cyc);
    logic took;
    sel = s; valid = 1'b1; data = d; last = l; cyc = 0;
    do begin
      @(negedge clk);
      took = s ? rdy_b : rdy_a;
      @(posedge clk); #1;
      cyc++;
    end while (!took && cyc < 50);
    if (!took) chk("send_timeout", 0, 1);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    rst_n = 1'b0; valid = 1'b0; sel = 1'b0; last = 1'b0; ready = 1'b1; data = '0;

    // Reset values
    #12;
    chk("rst_valid", vld_a, 0);
    chk("rst_ready", rdy_a, 1);
    chk("rst_result", res_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_term1", t1_a, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame of 16 x 0xFFF
    q_a.push_back('{16'hFFF0, 5'd16, 1'b0});
    for (int i = 0; i < 16; i++) send(1'b0, 12'hFFF, 1'b0, cyc);
    chk("full_hold_ready", rdy_a, 0);
    chk("full_hold_valid", vld_a, 1);
    tick(1);
    chk("full_ready_back", rdy_a, 1);

    // Early close then a one-sample frame
    q_a.push_back('{16'd6, 5'd3, 1'b0});
    send(1'b0, 12'd1, 1'b0, cyc);
    send(1'b0, 12'd2, 1'b0, cyc);
    send(1'b0, 12'd3, 1'b1, cyc);
    q_a.push_back('{16'd5, 5'd1, 1'b0});
    send(1'b0, 12'd5, 1'b1, cyc);
    chk("early_next_wait", cyc, 2);
    tick(1);

    // Backpressure
    ready = 1'b0;
    q_a.push_back('{16'd9, 5'd1, 1'b0});
    send(1'b0, 12'd9, 1'b1, cyc);
    sel = 1'b0; valid = 1'b1; data = 12'd7; last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", rdy_a, 0);
      chk("bp_valid", vld_a, 1);
      chk("bp_result", res_a, 9);
      chk("bp_count", cnt_a, 1);
      chk("bp_term2", t2_a, 0);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    q_a.push_back('{16'd7, 5'd1, 1'b0});
    tick(1);
    send(1'b0, 12'd7, 1'b1, cyc);
    chk("bp_first_accept_cycles", cyc, 1);
    tick(1);

    // Bubbles: i_valid toggling
    q_a.push_back('{16'h0010, 5'd16, 1'b0});
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 12'd1, 1'b0, cyc);
      @(negedge clk);
      if (i < 15) chk("bubble_term2", t2_a, 0);
      @(posedge clk); #1;
    end
    tick(1);

    // Saturation on the FRAME_LEN=20 instance
    q_b.push_back('{16'hFFEC, 5'd20, 1'b1});
    for (int i = 0; i < 20; i++) send(1'b1, 12'hFFF, 1'b0, cyc);
    q_b.push_back('{16'd1, 5'd1, 1'b0});
    send(1'b1, 12'd1, 1'b1, cyc);
    tick(2);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send(1'b0, 12'h800, 1'b0, cyc);
    chk("pre_rst_term1", t1_a, 12'h800);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", vld_a, 0);
    chk("mid_rst_ready", rdy_a, 1);
    chk("mid_rst_result", res_a, 0);
    chk("mid_rst_count", cnt_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    chk("mid_rst_term1", t1_a, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    q_a.push_back('{16'h0010, 5'd16, 1'b0});
    for (int i = 0; i < 16; i++) send(1'b0, 12'd1, 1'b0, cyc);
    tick(3);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
